fp_classify_pipe: RTL and testbench

- Parametrised, registered IEEE-754 classifier for any binary format (FP16/FP32/FP64 via EXP_W/MANT_W).
- Accepts operands on a valid/ready stream and returns a 10-bit one-hot class mask (RISC-V FCLASS bit order) with the operand one cycle later.
- Optional per-operand denormals-are-zero (DAZ) mode.
- Per-class saturating event counters for FPU exception/statistics logic, readable through a select port.

---
 rtl/fp_classify_pipe.sv | 112 +++++++++++
 tb/tb_fp_classify_pipe.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_classify_pipe.sv
// Registered IEEE-754 classifier: one-hot FCLASS mask plus optional DAZ flush,
// with per-class saturating event counters readable through a select port.
module fp_classify_pipe #(
    parameter int EXP_W  = 11,
    parameter int MANT_W = 52,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+MANT_W:0]   in_data,
    input  logic                    in_daz,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+MANT_W:0]   out_data,
    output logic [9:0]              out_class,
    input  logic                    cnt_clear,
    input  logic [3:0]              cnt_sel,
    output logic [CNT_W-1:0]        cnt_value
);
    localparam int W = 1 + EXP_W + MANT_W;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                w_sign;
    logic [EXP_W-1:0]    w_exp;
    logic [MANT_W-1:0]   w_mant;
    logic                w_exp_ones;
    logic                w_exp_zero;
    logic                w_mant_zero;
    logic                w_flush;
    logic                w_accept;
    logic [9:0]          w_class;
    logic [W-1:0]        w_data;

    logic                r_valid;
    logic [W-1:0]        r_data;
    logic [9:0]          r_class;
    logic [CNT_W-1:0]    r_cnt [10];

    assign w_sign      = in_data[W-1];
    assign w_exp       = in_data[W-2:MANT_W];
    assign w_mant      = in_data[MANT_W-1:0];
    assign w_exp_ones  = &w_exp;
    assign w_exp_zero  = ~|w_exp;
    assign w_mant_zero = ~|w_mant;
    assign w_flush     = in_daz && w_exp_zero && !w_mant_zero;

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // A flushed denormal becomes a zero of the same sign.
    assign w_data = w_flush ? {w_sign, {(W-1){1'b0}}} : in_data;

    always_comb begin
        w_class = '0;
        if (w_exp_ones) begin
            if (w_mant_zero)
                w_class[w_sign ? 0 : 7] = 1'b1;
            else if (w_mant[MANT_W-1])
                w_class[9] = 1'b1;
            else
                w_class[8] = 1'b1;
        end else if (w_exp_zero) begin
            if (w_mant_zero || w_flush)
                w_class[w_sign ? 3 : 4] = 1'b1;
            else
                w_class[w_sign ? 2 : 5] = 1'b1;
        end else begin
            w_class[w_sign ? 1 : 6] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_class <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= w_data;
            r_class <= w_class;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Clear has priority over counting an operand accepted in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 10; i++) r_cnt[i] <= '0;
        end else if (cnt_clear) begin
            for (int i = 0; i < 10; i++) r_cnt[i] <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < 10; i++)
                if (w_class[i] && (r_cnt[i] != CNT_MAX))
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
    end

    always_comb begin
        cnt_value = '0;
        for (int i = 0; i < 10; i++)
            if (cnt_sel == 4'(i)) cnt_value = r_cnt[i];
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_class = r_class;

endmodule

// File: tb/tb_fp_classify_pipe.sv
// Directed bench for fp_classify_pipe: FP64 default, FP64 with 2-bit counters,
// and an FP32 instance sharing one clock and reset.
module tb_fp_classify_pipe;
    logic clk;
    logic rst_n;

    int n_assert;
    int n_fail;

    // FP64, default counters
    logic        a_in_valid, a_in_ready, a_in_daz, a_out_valid, a_out_ready, a_cnt_clear;
    logic [63:0] a_in_data, a_out_data;
    logic [9:0]  a_out_class;
    logic [3:0]  a_cnt_sel;
    logic [15:0] a_cnt_value;

    // FP64, 2-bit counters
    logic        b_in_valid, b_in_ready, b_in_daz, b_out_valid, b_out_ready, b_cnt_clear;
    logic [63:0] b_in_data, b_out_data;
    logic [9:0]  b_out_class;
    logic [3:0]  b_cnt_sel;
    logic [1:0]  b_cnt_value;

    // FP32
    logic        c_in_valid, c_in_ready, c_in_daz, c_out_valid, c_out_ready, c_cnt_clear;
    logic [31:0] c_in_data, c_out_data;
    logic [9:0]  c_out_class;
    logic [3:0]  c_cnt_sel;
    logic [15:0] c_cnt_value;

    fp_classify_pipe u_d64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_daz(a_in_daz),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_class(a_out_class), .cnt_clear(a_cnt_clear), .cnt_sel(a_cnt_sel),
        .cnt_value(a_cnt_value)
    );

    fp_classify_pipe #(.EXP_W(11), .MANT_W(52), .CNT_W(2)) u_c2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_daz(b_in_daz),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_class(b_out_class), .cnt_clear(b_cnt_clear), .cnt_sel(b_cnt_sel),
        .cnt_value(b_cnt_value)
    );

    fp_classify_pipe #(.EXP_W(8), .MANT_W(23), .CNT_W(16)) u_f32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data), .in_daz(c_in_daz),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .out_class(c_out_class), .cnt_clear(c_cnt_clear), .cnt_sel(c_cnt_sel),
        .cnt_value(c_cnt_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        a_in_valid = 0; a_in_daz = 0; a_out_ready = 1; a_cnt_clear = 0; a_cnt_sel = 0; a_in_data = '0;
        b_in_valid = 0; b_in_daz = 0; b_out_ready = 1; b_cnt_clear = 0; b_cnt_sel = 0; b_in_data = '0;
        c_in_valid = 0; c_in_daz = 0; c_out_ready = 1; c_cnt_clear = 0; c_cnt_sel = 0; c_in_data = '0;

        // reset state
        #12;
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_class", 64'(a_out_class), 64'd0);
        chk("rst_out_data",  a_out_data, 64'd0);
        chk("rst_in_ready",  64'(a_in_ready), 64'd1);
        chk("rst_cnt0",      64'(a_cnt_value), 64'd0);
        rst_n = 1'b1;
        tick();

        // back-to-back FP64 classification
        a_in_valid = 1; a_in_data = 64'h7FF8000000000000;
        tick();
        chk("b2b_qnan_valid", 64'(a_out_valid), 64'd1);
        chk("b2b_qnan",  64'(a_out_class), 64'h200);
        a_in_data = 64'h7FF0000000000001;
        tick();
        chk("b2b_snan",  64'(a_out_class), 64'h100);
        a_in_data = 64'hFFF0000000000000;
        tick();
        chk("b2b_neginf", 64'(a_out_class), 64'h001);
        a_in_data = 64'h3FF0000000000000;
        tick();
        chk("b2b_posnorm", 64'(a_out_class), 64'h040);
        chk("b2b_posnorm_data", a_out_data, 64'h3FF0000000000000);
        a_in_valid = 0;
        tick();
        chk("b2b_drain_valid", 64'(a_out_valid), 64'd0);
        a_cnt_sel = 9; #1 chk("cnt_qnan", 64'(a_cnt_value), 64'd1);
        a_cnt_sel = 8; #1 chk("cnt_snan", 64'(a_cnt_value), 64'd1);
        a_cnt_sel = 0; #1 chk("cnt_neginf", 64'(a_cnt_value), 64'd1);

        // DAZ on and off for a negative denormal
        a_in_valid = 1; a_in_daz = 1; a_in_data = 64'h8000000000000001;
        tick();
        chk("daz_class", 64'(a_out_class), 64'h008);
        chk("daz_data",  a_out_data, 64'h8000000000000000);
        a_in_daz = 0;
        tick();
        chk("nodaz_class", 64'(a_out_class), 64'h004);
        chk("nodaz_data",  a_out_data, 64'h8000000000000001);
        a_in_valid = 0;
        tick();

        // backpressure
        a_out_ready = 0; a_in_valid = 1; a_in_data = 64'h3FF0000000000000;
        tick();
        chk("bp_valid", 64'(a_out_valid), 64'd1);
        a_in_data = 64'h0000000000000000;
        #1 chk("bp_in_ready", 64'(a_in_ready), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_class", 64'(a_out_class), 64'h040);
            chk("bp_hold_data",  a_out_data, 64'h3FF0000000000000);
            chk("bp_hold_ready", 64'(a_in_ready), 64'd0);
        end
        a_out_ready = 1;
        #1 chk("bp_release_ready", 64'(a_in_ready), 64'd1);
        tick();
        chk("bp_second_valid", 64'(a_out_valid), 64'd1);
        chk("bp_second_class", 64'(a_out_class), 64'h010);
        chk("bp_second_data",  a_out_data, 64'd0);
        a_in_valid = 0;
        tick();
        chk("bp_drain_valid", 64'(a_out_valid), 64'd0);
        a_cnt_sel = 4; #1 chk("cnt_poszero", 64'(a_cnt_value), 64'd1);
        a_cnt_sel = 6; #1 chk("cnt_posnorm", 64'(a_cnt_value), 64'd2);
        a_cnt_sel = 3; #1 chk("cnt_negzero", 64'(a_cnt_value), 64'd1);
        a_cnt_sel = 2; #1 chk("cnt_negden",  64'(a_cnt_value), 64'd1);

        // 2-bit counter saturation, clear priority, out-of-range select
        b_in_valid = 1; b_in_data = 64'h0;
        for (int i = 0; i < 5; i++) tick();
        b_in_valid = 0; b_cnt_sel = 4;
        #1 chk("sat_cnt", 64'(b_cnt_value), 64'd3);
        b_cnt_clear = 1; b_in_valid = 1;
        tick();
        b_cnt_clear = 0; b_in_valid = 0;
        #1 chk("clear_cnt", 64'(b_cnt_value), 64'd0);
        chk("clear_class", 64'(b_out_class), 64'h010);
        b_in_valid = 1;
        tick();
        b_in_valid = 0;
        #1 chk("post_clear_cnt", 64'(b_cnt_value), 64'd1);
        b_cnt_sel = 12;
        #1 chk("sel_oob", 64'(b_cnt_value), 64'd0);

        // FP32 instance
        c_in_valid = 1; c_in_data = 32'h00000001;
        tick();
        chk("f32_posden", 64'(c_out_class), 64'h020);
        c_in_data = 32'h7F800000;
        tick();
        chk("f32_posinf", 64'(c_out_class), 64'h080);
        c_in_data = 32'h7FC00000;
        tick();
        chk("f32_qnan", 64'(c_out_class), 64'h200);
        c_in_valid = 0;
        tick();

        // async reset mid-stream
        a_out_ready = 0; a_in_valid = 1; a_in_data = 64'h3FF0000000000000;
        tick();
        a_in_valid = 0; a_cnt_sel = 6;
        #1 chk("pre_rst_valid", 64'(a_out_valid), 64'd1);
        chk("pre_rst_cnt", 64'(a_cnt_value), 64'd3);
        rst_n = 0;
        #1;
        chk("async_rst_valid", 64'(a_out_valid), 64'd0);
        chk("async_rst_class", 64'(a_out_class), 64'd0);
        chk("async_rst_cnt6",  64'(a_cnt_value), 64'd0);
        a_cnt_sel = 4;
        #1 chk("async_rst_cnt4", 64'(a_cnt_value), 64'd0);
        chk("async_rst_b_cnt", 64'(b_cnt_value), 64'd0);
        tick();
        rst_n = 1; a_out_ready = 1;
        tick();
        a_in_valid = 1; a_in_data = 64'h7FF0000000000000;
        tick();
        chk("resume_valid", 64'(a_out_valid), 64'd1);
        chk("resume_class", 64'(a_out_class), 64'h080);
        a_in_valid = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
